// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MDU_XLEN  = 32;
  localparam int unsigned MDU_ITER  = 32;
  localparam int unsigned MDU_CNT_W = 5;

  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_MULT  = 2'b01;
  localparam logic [1:0] MDU_DIVU  = 2'b10;
  localparam logic [1:0] MDU_DIV   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  // Magnitude of v when it is to be treated as signed, v unchanged otherwise.
  function automatic logic [MDU_XLEN-1:0] mdu_abs(input logic [MDU_XLEN-1:0] v,
                                                  input logic sgn);
    return (sgn && v[MDU_XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_addsub.sv
// Adder/subtractor shared by the multiply add step and the divide trial subtract.
module mdu_addsub #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W-1:0] b_eff;

  assign b_eff = sub ? ~b : b;
  // For subtract, carry=1 means a >= b (no borrow).
  assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};

endmodule

// File: rtl/mdu_sequencer.sv
// EX-stage multiply/divide sequencer: 32-step shift-add / restoring divide, owns HI/LO.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN  = MDU_XLEN,
  parameter int unsigned ITER  = MDU_ITER,
  parameter int unsigned CNT_W = MDU_CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rsData,
  input  logic [XLEN-1:0] rtData,
  input  logic            writeHi,
  input  logic            writeLo,
  input  logic [XLEN-1:0] wrData,
  input  logic            readHiLo,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2*XLEN-1:0]   acc;      // MUL: {product_hi, product_lo/multiplier}; DIV: {rem, quo}
  logic [XLEN-1:0]     opd;      // multiplicand or divisor magnitude
  logic [XLEN-1:0]     rs_raw;
  logic                is_div;
  logic                neg_res;
  logic                neg_rem;
  logic                div0;

  logic                op_div;
  logic                op_sgn;
  logic [XLEN:0]       as_a;
  logic [XLEN:0]       as_b;
  logic [XLEN:0]       as_sum;
  logic                as_carry;
  logic [2*XLEN-1:0]   acc_nxt;
  logic [XLEN-1:0]     res_hi;
  logic [XLEN-1:0]     res_lo;

  assign op_div = (op == MDU_DIVU) || (op == MDU_DIV);
  assign op_sgn = (op == MDU_MULT) || (op == MDU_DIV);

  assign busy  = (state != S_IDLE);
  assign stall = busy & (start | readHiLo | writeHi | writeLo);

  // DIV feeds the shifted remainder (33 bits incl. the bit shifted out of acc).
  assign as_a = is_div ? acc[2*XLEN-1:XLEN-1] : {1'b0, acc[2*XLEN-1:XLEN]};
  assign as_b = {1'b0, opd};

  mdu_addsub #(.W(XLEN + 1)) u_addsub (
    .a     (as_a),
    .b     (as_b),
    .sub   (is_div),
    .sum   (as_sum),
    .carry (as_carry)
  );

  always_comb begin
    acc_nxt = acc;
    if (is_div) begin
      if (as_carry) acc_nxt = {as_sum[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else          acc_nxt = {acc[2*XLEN-2:0], 1'b0};
    end else begin
      if (acc[0]) acc_nxt = {as_sum, acc[XLEN-1:1]};
      else        acc_nxt = {1'b0, acc[2*XLEN-1:1]};
    end
  end

  always_comb begin
    res_hi = acc[2*XLEN-1:XLEN];
    res_lo = acc[XLEN-1:0];
    if (div0) begin
      res_hi = rs_raw;
      res_lo = '1;
    end else if (is_div) begin
      if (neg_res) res_lo = -acc[XLEN-1:0];
      if (neg_rem) res_hi = -acc[2*XLEN-1:XLEN];
    end else if (neg_res) begin
      {res_hi, res_lo} = -acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      opd     <= '0;
      rs_raw  <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (start) begin
            is_div  <= op_div;
            neg_res <= op_sgn & (rsData[XLEN-1] ^ rtData[XLEN-1]);
            neg_rem <= op_sgn & rsData[XLEN-1];
            div0    <= op_div & (rtData == '0);
            rs_raw  <= rsData;
            opd     <= op_div ? mdu_abs(rtData, op_sgn) : mdu_abs(rsData, op_sgn);
            acc     <= {{XLEN{1'b0}}, op_div ? mdu_abs(rsData, op_sgn) : mdu_abs(rtData, op_sgn)};
            cnt     <= '0;
            state   <= S_RUN;
          end else begin
            if (writeHi) hi <= wrData;
            if (writeLo) lo <= wrData;
          end
        end
        S_RUN: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(ITER - 1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          if (!flush) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
